// File: rtl/fcpu_pkg.sv
// Shared core-wide widths and the reorder-buffer entry layout.
package fcpu_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int RSV_ID_W   = 3;
    localparam int ROB_DEPTH  = 2**RSV_ID_W;

    typedef struct packed {
        logic                  valid;
        logic                  done;
        logic                  is_void;
        logic                  has_dst;
        logic [REG_ADDR_W-1:0] dst;
        logic [DATA_W-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, writeback, operand-lookup and commit bundle between the core and the ROB.
interface reorder_buffer_if
    import fcpu_pkg::*;
#(
    parameter int N_RD_PORTS = 2
);
    logic                                 alloc_valid;
    logic                                 alloc_ready;
    logic                                 alloc_has_dst;
    logic [REG_ADDR_W-1:0]                alloc_dst;
    logic [RSV_ID_W-1:0]                  alloc_id;

    logic                                 wb_valid;
    logic [RSV_ID_W-1:0]                  wb_id;
    logic [DATA_W-1:0]                    wb_data;
    logic                                 wb_void;

    logic [N_RD_PORTS-1:0][RSV_ID_W-1:0]  rd_ids;
    logic [N_RD_PORTS-1:0][DATA_W-1:0]    rd_data;
    logic [N_RD_PORTS-1:0]                rd_done;

    logic                                 flush;

    logic                                 we;
    logic                                 we_invalidate;
    logic [RSV_ID_W-1:0]                  wrQueAddr;
    logic [REG_ADDR_W-1:0]                wrAddr;
    logic [DATA_W-1:0]                    wrData;
    logic [RSV_ID_W:0]                    count;

    modport master (
        output alloc_valid, alloc_has_dst, alloc_dst,
        output wb_valid, wb_id, wb_data, wb_void,
        output rd_ids, flush,
        input  alloc_ready, alloc_id, rd_data, rd_done,
        input  we, we_invalidate, wrQueAddr, wrAddr, wrData, count
    );

    modport slave (
        input  alloc_valid, alloc_has_dst, alloc_dst,
        input  wb_valid, wb_id, wb_data, wb_void,
        input  rd_ids, flush,
        output alloc_ready, alloc_id, rd_data, rd_done,
        output we, we_invalidate, wrQueAddr, wrAddr, wrData, count
    );
endinterface

// File: rtl/reorder_buffer_lookup.sv
// Operand tag read with same-cycle writeback forwarding; combinational, zero latency.
// No backpressure: every lookup is answered in the cycle it is presented.
module rob_lookup
    import fcpu_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH
) (
    input  logic [RSV_ID_W-1:0] rd_id,
    input  logic [DEPTH-1:0]    ent_ready,
    input  logic [DATA_W-1:0]   ent_data [DEPTH],
    input  logic                wb_valid,
    input  logic [RSV_ID_W-1:0] wb_id,
    input  logic [DATA_W-1:0]   wb_data,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_done
);

    always_comb begin
        rd_data = ent_data[rd_id];
        rd_done = ent_ready[rd_id];
        // A result on the bus this cycle is newer than anything stored.
        if (wb_valid && (wb_id == rd_id)) begin
            rd_data = wb_data;
            rd_done = 1'b1;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates tags, gathers out-of-order results, commits the head.
// Commit one edge after the head completes; alloc_ready from registered count only (no same-cycle credit).
module reorder_buffer
    import fcpu_pkg::*;
#(
    parameter int N_RD_PORTS = 2,
    parameter int DEPTH      = ROB_DEPTH   // must be 2**RSV_ID_W so pointers wrap for free
) (
    input  logic              clk,
    input  logic              nrst,
    reorder_buffer_if.slave   rob
);

    rob_entry_t            entries [DEPTH];
    logic [RSV_ID_W-1:0]   head;
    logic [RSV_ID_W-1:0]   tail;
    logic [RSV_ID_W:0]     count_q;

    logic                  alloc_fire;
    logic                  wb_fire;
    logic                  commit_fire;
    rob_entry_t            head_ent;

    logic [DEPTH-1:0]      ent_ready;
    logic [DATA_W-1:0]     ent_data [DEPTH];

    assign head_ent        = entries[head];
    assign rob.alloc_ready = (count_q < (RSV_ID_W+1)'(DEPTH));
    assign rob.alloc_id    = tail;
    assign rob.count       = count_q;

    assign alloc_fire  = rob.alloc_valid && rob.alloc_ready && !rob.flush;
    assign wb_fire     = rob.wb_valid && !rob.flush && entries[rob.wb_id].valid;
    assign commit_fire = head_ent.valid && head_ent.done && !rob.flush;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_ready[i] = entries[i].valid && entries[i].done;
            ent_data[i]  = entries[i].data;
        end
    end

    for (genvar p = 0; p < N_RD_PORTS; p++) begin : g_rd
        rob_lookup #(.DEPTH(DEPTH)) u_lookup (
            .rd_id     (rob.rd_ids[p]),
            .ent_ready (ent_ready),
            .ent_data  (ent_data),
            .wb_valid  (rob.wb_valid),
            .wb_id     (rob.wb_id),
            .wb_data   (rob.wb_data),
            .rd_data   (rob.rd_data[p]),
            .rd_done   (rob.rd_done[p])
        );
    end

    // Entry storage. Allocation only targets the tail, which is never a live entry while not full.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (rob.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (wb_fire) begin
                entries[rob.wb_id].done    <= 1'b1;
                entries[rob.wb_id].data    <= rob.wb_data;
                entries[rob.wb_id].is_void <= rob.wb_void;
            end
            if (commit_fire) begin
                entries[head].valid <= 1'b0;
            end
            if (alloc_fire) begin
                entries[tail].valid   <= 1'b1;
                entries[tail].done    <= 1'b0;
                entries[tail].is_void <= 1'b0;
                entries[tail].has_dst <= rob.alloc_has_dst;
                entries[tail].dst     <= rob.alloc_dst;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (rob.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + 1'b1;
            end
            if (commit_fire) begin
                head <= head + 1'b1;
            end
            case ({alloc_fire, commit_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Register-file write port; address/data hold between commits, strobes are single-cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rob.we            <= 1'b0;
            rob.we_invalidate <= 1'b0;
            rob.wrQueAddr     <= '0;
            rob.wrAddr        <= '0;
            rob.wrData        <= '0;
        end else if (commit_fire) begin
            rob.we            <= 1'b1;
            rob.we_invalidate <= head_ent.is_void | ~head_ent.has_dst;
            rob.wrQueAddr     <= head;
            rob.wrAddr        <= head_ent.dst;
            rob.wrData        <= head_ent.data;
        end else begin
            rob.we            <= 1'b0;
            rob.we_invalidate <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer (RSV_ID_W=3, DEPTH=8) with hand-computed expectations.
module tb_reorder_buffer;
    import fcpu_pkg::*;

    int   total = 0;
    int   bad   = 0;
    logic clk   = 1'b0;
    logic nrst  = 1'b0;

    always #5 clk = ~clk;

    reorder_buffer_if #(.N_RD_PORTS(2)) rob_if ();

    reorder_buffer #(.N_RD_PORTS(2), .DEPTH(8)) dut (
        .clk  (clk),
        .nrst (nrst),
        .rob  (rob_if)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rob_if.alloc_valid   = 1'b0;
        rob_if.alloc_has_dst = 1'b0;
        rob_if.alloc_dst     = '0;
        rob_if.wb_valid      = 1'b0;
        rob_if.wb_id         = '0;
        rob_if.wb_data       = '0;
        rob_if.wb_void       = 1'b0;
        rob_if.rd_ids        = '0;
        rob_if.flush         = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic alloc_n(input int n, input logic has_dst);
        for (int i = 0; i < n; i++) begin
            rob_if.alloc_valid   = 1'b1;
            rob_if.alloc_has_dst = has_dst;
            rob_if.alloc_dst     = REG_ADDR_W'(i + 1);
            step();
        end
        rob_if.alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nrst = 1'b0;
        #2;
        total++; if (rob_if.count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", rob_if.count); end
        total++; if (rob_if.we !== 1'b0 || rob_if.we_invalidate !== 1'b0) begin bad++; $display("FAIL reset_we got=%b%b exp=00", rob_if.we, rob_if.we_invalidate); end
        total++; if (rob_if.alloc_ready !== 1'b1 || rob_if.alloc_id !== 3'd0) begin bad++; $display("FAIL reset_alloc got=%b/%0d exp=1/0", rob_if.alloc_ready, rob_if.alloc_id); end
        total++; if (rob_if.wrData !== 32'd0 || rob_if.wrAddr !== 5'd0 || rob_if.wrQueAddr !== 3'd0) begin bad++; $display("FAIL reset_wr got=%h/%0d/%0d exp=0/0/0", rob_if.wrData, rob_if.wrAddr, rob_if.wrQueAddr); end
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic test_basic_commit();
        do_reset();
        rob_if.alloc_valid   = 1'b1;
        rob_if.alloc_has_dst = 1'b1;
        rob_if.alloc_dst     = 5'd5;
        #1;
        total++; if (rob_if.alloc_id !== 3'd0) begin bad++; $display("FAIL basic_alloc_id got=%0d exp=0", rob_if.alloc_id); end
        step();
        rob_if.alloc_valid = 1'b0;
        total++; if (rob_if.count !== 4'd1) begin bad++; $display("FAIL basic_count1 got=%0d exp=1", rob_if.count); end
        rob_if.wb_valid = 1'b1;
        rob_if.wb_id    = 3'd0;
        rob_if.wb_data  = 32'hDEAD;
        step();
        rob_if.wb_valid = 1'b0;
        total++; if (rob_if.we !== 1'b0) begin bad++; $display("FAIL basic_we_early got=%b exp=0", rob_if.we); end
        step();
        total++; if (rob_if.we !== 1'b1 || rob_if.we_invalidate !== 1'b0) begin bad++; $display("FAIL basic_we got=%b%b exp=10", rob_if.we, rob_if.we_invalidate); end
        total++; if (rob_if.wrQueAddr !== 3'd0 || rob_if.wrAddr !== 5'd5 || rob_if.wrData !== 32'hDEAD) begin bad++; $display("FAIL basic_wr got=%0d/%0d/%h exp=0/5/dead", rob_if.wrQueAddr, rob_if.wrAddr, rob_if.wrData); end
        total++; if (rob_if.count !== 4'd0) begin bad++; $display("FAIL basic_count0 got=%0d exp=0", rob_if.count); end
        step();
        total++; if (rob_if.we !== 1'b0 || rob_if.wrData !== 32'hDEAD) begin bad++; $display("FAIL basic_pulse got=%b/%h exp=0/dead", rob_if.we, rob_if.wrData); end
    endtask

    task automatic test_out_of_order();
        logic [2:0]  wb_order [3] = '{3'd2, 3'd0, 3'd1};
        logic [31:0] exp_data [3] = '{32'h20, 32'h21, 32'h22};
        do_reset();
        alloc_n(3, 1'b1);
        total++; if (rob_if.count !== 4'd3) begin bad++; $display("FAIL ooo_count got=%0d exp=3", rob_if.count); end
        for (int i = 0; i < 3; i++) begin
            rob_if.wb_valid = 1'b1;
            rob_if.wb_id    = wb_order[i];
            rob_if.wb_data  = 32'h20 + 32'(wb_order[i]);
            step();
            if (i < 2) begin
                total++; if (rob_if.we !== 1'b0) begin bad++; $display("FAIL ooo_early_we%0d got=%b exp=0", i, rob_if.we); end
            end
        end
        rob_if.wb_valid = 1'b0;
        // id0 completed at the second writeback edge, so its commit lands at the third
        total++; if (rob_if.we !== 1'b1 || rob_if.wrQueAddr !== 3'd0 || rob_if.wrData !== exp_data[0]) begin bad++; $display("FAIL ooo_commit0 got=%b/%0d/%h exp=1/0/%h", rob_if.we, rob_if.wrQueAddr, rob_if.wrData, exp_data[0]); end
        for (int i = 1; i < 3; i++) begin
            step();
            total++; if (rob_if.we !== 1'b1 || rob_if.wrQueAddr !== 3'(i) || rob_if.wrData !== exp_data[i] || rob_if.wrAddr !== 5'(i + 1)) begin bad++; $display("FAIL ooo_commit%0d got=%b/%0d/%h/%0d exp=1/%0d/%h/%0d", i, rob_if.we, rob_if.wrQueAddr, rob_if.wrData, rob_if.wrAddr, i, exp_data[i], i + 1); end
        end
        step();
        total++; if (rob_if.we !== 1'b0 || rob_if.count !== 4'd0) begin bad++; $display("FAIL ooo_drain got=%b/%0d exp=0/0", rob_if.we, rob_if.count); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            rob_if.alloc_valid   = 1'b1;
            rob_if.alloc_has_dst = 1'b1;
            rob_if.alloc_dst     = 5'(i);
            #1;
            total++; if (rob_if.alloc_id !== 3'(i)) begin bad++; $display("FAIL full_id%0d got=%0d exp=%0d", i, rob_if.alloc_id, i); end
            step();
        end
        total++; if (rob_if.alloc_ready !== 1'b0 || rob_if.count !== 4'd8) begin bad++; $display("FAIL full_state got=%b/%0d exp=0/8", rob_if.alloc_ready, rob_if.count); end
        rob_if.wb_valid = 1'b1;
        rob_if.wb_id    = 3'd0;
        rob_if.wb_data  = 32'h100;
        step();
        rob_if.wb_valid = 1'b0;
        total++; if (rob_if.count !== 4'd8) begin bad++; $display("FAIL full_stall got=%0d exp=8", rob_if.count); end
        step();
        // commit edge: allocation still stalled since ready came from the old count
        total++; if (rob_if.we !== 1'b1 || rob_if.wrQueAddr !== 3'd0 || rob_if.count !== 4'd7) begin bad++; $display("FAIL full_commit got=%b/%0d/%0d exp=1/0/7", rob_if.we, rob_if.wrQueAddr, rob_if.count); end
        total++; if (rob_if.alloc_ready !== 1'b1 || rob_if.alloc_id !== 3'd0) begin bad++; $display("FAIL full_wrap got=%b/%0d exp=1/0", rob_if.alloc_ready, rob_if.alloc_id); end
        step();
        rob_if.alloc_valid = 1'b0;
        total++; if (rob_if.count !== 4'd8 || rob_if.alloc_id !== 3'd1) begin bad++; $display("FAIL full_realloc got=%0d/%0d exp=8/1", rob_if.count, rob_if.alloc_id); end
    endtask

    task automatic test_void();
        do_reset();
        alloc_n(1, 1'b0);
        alloc_n(1, 1'b1);
        rob_if.wb_valid = 1'b1;
        rob_if.wb_id    = 3'd0;
        rob_if.wb_data  = 32'h1;
        rob_if.wb_void  = 1'b0;
        step();
        rob_if.wb_id    = 3'd1;
        rob_if.wb_data  = 32'h2;
        rob_if.wb_void  = 1'b1;
        step();
        rob_if.wb_valid = 1'b0;
        rob_if.wb_void  = 1'b0;
        total++; if (rob_if.we !== 1'b1 || rob_if.we_invalidate !== 1'b1 || rob_if.wrQueAddr !== 3'd0) begin bad++; $display("FAIL void_nodst got=%b%b/%0d exp=11/0", rob_if.we, rob_if.we_invalidate, rob_if.wrQueAddr); end
        step();
        total++; if (rob_if.we !== 1'b1 || rob_if.we_invalidate !== 1'b1 || rob_if.wrQueAddr !== 3'd1 || rob_if.wrData !== 32'h2) begin bad++; $display("FAIL void_wb got=%b%b/%0d/%h exp=11/1/2", rob_if.we, rob_if.we_invalidate, rob_if.wrQueAddr, rob_if.wrData); end
        step();
        total++; if (rob_if.we !== 1'b0 || rob_if.we_invalidate !== 1'b0) begin bad++; $display("FAIL void_clear got=%b%b exp=00", rob_if.we, rob_if.we_invalidate); end
    endtask

    task automatic test_lookup();
        do_reset();
        alloc_n(4, 1'b1);
        rob_if.rd_ids[0] = 3'd3;
        rob_if.rd_ids[1] = 3'd2;
        #1;
        total++; if (rob_if.rd_done !== 2'b00) begin bad++; $display("FAIL lk_pending got=%b exp=00", rob_if.rd_done); end
        rob_if.rd_ids[1] = 3'd6;
        rob_if.wb_valid  = 1'b1;
        rob_if.wb_id     = 3'd3;
        rob_if.wb_data   = 32'h1234;
        #1;
        total++; if (rob_if.rd_done[0] !== 1'b1 || rob_if.rd_data[0] !== 32'h1234) begin bad++; $display("FAIL lk_forward got=%b/%h exp=1/1234", rob_if.rd_done[0], rob_if.rd_data[0]); end
        total++; if (rob_if.rd_done[1] !== 1'b0) begin bad++; $display("FAIL lk_unalloc got=%b exp=0", rob_if.rd_done[1]); end
        step();
        rob_if.wb_valid  = 1'b0;
        rob_if.rd_ids[1] = 3'd3;
        rob_if.rd_ids[0] = 3'd0;
        #1;
        total++; if (rob_if.rd_done !== 2'b10 || rob_if.rd_data[1] !== 32'h1234) begin bad++; $display("FAIL lk_stored got=%b/%h exp=10/1234", rob_if.rd_done, rob_if.rd_data[1]); end
    endtask

    task automatic test_flush_and_reset();
        do_reset();
        alloc_n(4, 1'b1);
        rob_if.wb_valid = 1'b1;
        rob_if.wb_id    = 3'd0;
        rob_if.wb_data  = 32'h55;
        step();
        // head is complete; flush must discard its commit plus the new alloc and wb
        rob_if.flush         = 1'b1;
        rob_if.alloc_valid   = 1'b1;
        rob_if.alloc_has_dst = 1'b1;
        rob_if.wb_id         = 3'd1;
        rob_if.wb_data       = 32'h66;
        #1;
        total++; if (rob_if.alloc_ready !== 1'b1) begin bad++; $display("FAIL fl_ready got=%b exp=1", rob_if.alloc_ready); end
        step();
        idle_inputs();
        total++; if (rob_if.count !== 4'd0 || rob_if.we !== 1'b0 || rob_if.alloc_id !== 3'd0) begin bad++; $display("FAIL fl_state got=%0d/%b/%0d exp=0/0/0", rob_if.count, rob_if.we, rob_if.alloc_id); end
        rob_if.rd_ids[0] = 3'd0;
        rob_if.rd_ids[1] = 3'd1;
        #1;
        total++; if (rob_if.rd_done !== 2'b00) begin bad++; $display("FAIL fl_rd got=%b exp=00", rob_if.rd_done); end
        step();
        total++; if (rob_if.we !== 1'b0) begin bad++; $display("FAIL fl_nocommit got=%b exp=0", rob_if.we); end

        alloc_n(1, 1'b1);
        rob_if.wb_valid = 1'b1;
        rob_if.wb_id    = 3'd0;
        rob_if.wb_data  = 32'hBEEF;
        step();
        rob_if.wb_valid = 1'b0;
        step();
        total++; if (rob_if.we !== 1'b1 || rob_if.wrData !== 32'hBEEF) begin bad++; $display("FAIL rst_pre got=%b/%h exp=1/beef", rob_if.we, rob_if.wrData); end
        #2;
        nrst = 1'b0;
        #1;
        total++; if (rob_if.we !== 1'b0 || rob_if.count !== 4'd0 || rob_if.wrData !== 32'd0 || rob_if.alloc_id !== 3'd0) begin bad++; $display("FAIL rst_async got=%b/%0d/%h/%0d exp=0/0/0/0", rob_if.we, rob_if.count, rob_if.wrData, rob_if.alloc_id); end
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_out_of_order();
        test_full();
        test_void();
        test_lookup();
        test_flush_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
